// File: rtl/if_pc_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack port plus the IF/ID presentation port.
// The master modport is the fetch unit's view; slave is the memory/pipeline side.
interface if_pc_fetch_if #(
   parameter int XLEN = 32
);
   // Control from the rest of the pipeline
   logic            stall_i;
   logic            redirect_i;
   logic [XLEN-1:0] redirect_pc_i;

   // Instruction memory: a word moves when imem_req_o & imem_ack_i at a rising edge.
   // imem_req_o is not withdrawn without an ack except by reset or redirect, and
   // imem_addr_o stays stable while req is waiting; imem_rdata_i is used only in the ack cycle.
   // On the IF/ID side an instruction is taken when if_valid_o & ~stall_i at a rising edge.
   logic            imem_req_o;
   logic [XLEN-1:0] imem_addr_o;
   logic            imem_ack_i;
   logic [XLEN-1:0] imem_rdata_i;

   // Presentation to the IF/ID register
   logic            if_valid_o;
   logic [XLEN-1:0] if_pc_o;
   logic [XLEN-1:0] if_pc_plus4_o;
   logic [XLEN-1:0] if_instr_o;

   modport master (
      input  stall_i, redirect_i, redirect_pc_i, imem_ack_i, imem_rdata_i,
      output imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_pc_plus4_o, if_instr_o
   );

   modport slave (
      output stall_i, redirect_i, redirect_pc_i, imem_ack_i, imem_rdata_i,
      input  imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_pc_plus4_o, if_instr_o
   );
endinterface

// File: rtl/if_pc_fetch.sv
// IF-stage program counter and fetch control: one fetch per cycle, output register plus
// one-entry skid buffer, carry-select PC+4, and redirect handling from EX.
module if_pc_fetch #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   if_pc_fetch_if.master    bus,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam int              NSLICE     = XLEN / 4;
   localparam logic [XLEN-1:0] INC        = XLEN'(4);
   localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

   state_t          state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus4;

   logic            out_valid;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_pc_plus4;
   logic [XLEN-1:0] out_instr;

   // Skid holds the word accepted while the output register was blocked;
   // it is occupied exactly while the FSM sits in HOLD.
   logic [XLEN-1:0] skid_pc;
   logic [XLEN-1:0] skid_pc_plus4;
   logic [XLEN-1:0] skid_instr;

   logic            req;
   logic            transfer;
   logic            consume;

   assign req      = (state == FETCH);
   assign transfer = req & bus.imem_ack_i;
   assign consume  = out_valid & ~bus.stall_i;

   // Carry-select PC+4: each 4-bit slice precomputes both carry-in cases and the
   // incoming carry only selects, so the critical path is one mux per slice.
   logic [NSLICE-1:0] carry;
   assign carry[0] = 1'b0;

   for (genvar g = 0; g < NSLICE; g++) begin : g_slice
      if (g < NSLICE - 1) begin : g_mid
         logic [4:0] sum0;
         logic [4:0] sum1;
         assign sum0 = {1'b0, pc[4*g +: 4]} + {1'b0, INC[4*g +: 4]};
         assign sum1 = {1'b0, pc[4*g +: 4]} + {1'b0, INC[4*g +: 4]} + 5'd1;
         assign pc_plus4[4*g +: 4] = carry[g] ? sum1[3:0] : sum0[3:0];
         assign carry[g+1]         = carry[g] ? sum1[4]   : sum0[4];
      end else begin : g_top
         // Top slice drops its carry-out: PC arithmetic wraps modulo 2^XLEN.
         logic [3:0] sum0;
         logic [3:0] sum1;
         assign sum0 = pc[4*g +: 4] + INC[4*g +: 4];
         assign sum1 = pc[4*g +: 4] + INC[4*g +: 4] + 4'd1;
         assign pc_plus4[4*g +: 4] = carry[g] ? sum1 : sum0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= BOOT;
         pc            <= RESET_PC;
         out_valid     <= 1'b0;
         out_pc        <= '0;
         out_pc_plus4  <= '0;
         out_instr     <= '0;
         skid_pc       <= '0;
         skid_pc_plus4 <= '0;
         skid_instr    <= '0;
      end else if (bus.redirect_i) begin
         // Redirect overrides stall, ack and consume; any word acked this cycle is dropped.
         pc        <= bus.redirect_pc_i & ALIGN_MASK;
         out_valid <= 1'b0;
         state     <= BOOT;
      end else begin
         case (state)
            BOOT: begin
               state <= FETCH;
               if (consume) out_valid <= 1'b0;
            end

            FETCH: begin
               if (transfer) begin
                  pc <= pc_plus4;
                  if (!out_valid || consume) begin
                     out_valid    <= 1'b1;
                     out_pc       <= pc;
                     out_pc_plus4 <= pc_plus4;
                     out_instr    <= bus.imem_rdata_i;
                  end else begin
                     skid_pc       <= pc;
                     skid_pc_plus4 <= pc_plus4;
                     skid_instr    <= bus.imem_rdata_i;
                     state         <= HOLD;
                  end
               end else if (consume) begin
                  out_valid <= 1'b0;
               end
            end

            HOLD: begin
               if (consume) begin
                  out_valid    <= 1'b1;
                  out_pc       <= skid_pc;
                  out_pc_plus4 <= skid_pc_plus4;
                  out_instr    <= skid_instr;
                  state        <= FETCH;
               end
            end

            default: state <= BOOT;
         endcase
      end
   end

   assign bus.imem_req_o    = req;
   assign bus.imem_addr_o   = pc;
   assign bus.if_valid_o    = out_valid;
   assign bus.if_pc_o       = out_pc;
   assign bus.if_pc_plus4_o = out_pc_plus4;
   assign bus.if_instr_o    = out_instr;
   assign dbg_state         = state;

endmodule

// File: doc/if_pc_fetch.md
Name: if_pc_fetch

Overview:
- Program-counter and fetch-control block of the IF stage.
- Holds the PC and issues word fetches to instruction memory over a req/ack handshake.
- Buffers returned instructions (output register plus one-entry skid) and presents them to the IF/ID pipeline register.
- Computes PC+4 through the IF-stage carry-select incrementer, built from 4-bit slices, and accepts branch/jump redirects from EX.

Parameters:
- XLEN, 32, PC and instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; low two bits must be 0.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- stall_i  input  1  from hazard unit; IF/ID not accepting this cycle.
- redirect_i  input  1  taken branch/jump from EX.
- redirect_pc_i  input  XLEN  redirect target.
- imem_req_o  output  1  fetch request.
- imem_addr_o  output  XLEN  fetch address (word aligned).
- imem_ack_i  input  1  memory accepts request and returns data this cycle.
- imem_rdata_i  input  XLEN  instruction, valid when req&ack.
- if_valid_o  output  1  if_instr_o/if_pc_o hold a valid instruction.
- if_pc_o  output  XLEN  PC of presented instruction.
- if_pc_plus4_o  output  XLEN  if_pc_o+4, for JAL/JALR link.
- if_instr_o  output  XLEN  presented instruction.

Behaviour:
- The whole block is clocked on clk. rst has priority over all other inputs.
- Reset (sampled at clk edge):
  - state=BOOT, pc=RESET_PC.
  - if_valid_o=0; if_pc_o, if_pc_plus4_o, if_instr_o=0.
  - Skid buffer empty. imem_req_o=0.
- imem_req_o = (state==FETCH). imem_addr_o = pc.
- Transfer occurs when imem_req_o&imem_ack_i are high at a clk edge. Latency is 0: data arrives in the ack cycle.
- Consume: if_valid_o=1 and stall_i=0 at a clk edge.
- State BOOT:
  - req=0.
  - Next state is FETCH, unless redirect_i is high: then pc<=redirect_pc_i&~3 and the state stays BOOT.
- State FETCH, transfer with output register free or being consumed:
  - Output <= {1, pc, pc+4, rdata}.
  - pc<=pc+4. Stay in FETCH, so the next request goes out the following cycle: one instruction per cycle at full throughput.
- State FETCH, transfer with output full and not consumed:
  - Skid <= {pc, rdata}.
  - pc<=pc+4. Next state HOLD.
- State FETCH, no transfer: hold pc and addr stable; req stays high.
- State HOLD:
  - req=0.
  - On consume: output <= skid, skid cleared, next state FETCH.
  - Otherwise hold everything.
- Output register with no transfer:
  - On consume, if_valid_o<=0.
  - Otherwise all outputs hold.
  - if_pc_o, if_pc_plus4_o and if_instr_o change only when a new instruction is loaded.
- redirect_i (any state except reset) beats stall_i, ack and consume:
  - pc<=redirect_pc_i with bits [1:0] forced to 0.
  - if_valid_o<=0, skid cleared.
  - Next state BOOT.
  - Any data acked in the same cycle is discarded.
  - New address appears with req=1 two cycles after the redirect edge; req is low for one cycle between.
- Addition is modulo 2^XLEN: pc 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- Simultaneous stall_i and redirect_i: redirect wins, and the output is invalidated regardless of stall.
- Reset mid-transaction: the outstanding request is abandoned. The memory must tolerate req dropping without ack on reset only.

Test Plan:
1. Reset with RESET_PC=0, ack always 1, stall 0, rst released at edge 0:
   - req=1 from the cycle after BOOT.
   - if_pc_o sequence 0,4,8,C on consecutive cycles; if_pc_plus4_o tracks +4.
   - if_instr_o equals the memory word at each address.
2. Stall for 3 cycles while output holds pc=8, ack=1:
   - PC 0xC is captured into skid; req drops (HOLD).
   - Output holds pc=8 for the 3 cycles.
   - After release: output pc=0xC, then req resumes at addr 0x10 the next cycle; no instruction is lost or duplicated.
3. ack held low for 5 cycles at addr 0x20:
   - req and addr stay stable at 0x20.
   - if_valid_o drops after the prior instruction is consumed.
   - When ack rises, pc=0x20 is delivered.
4. redirect_i with redirect_pc_i=0x0000_0103 in the same cycle as an ack at addr 0x40:
   - 0x40 data is discarded; if_valid_o=0 next cycle.
   - req low for one cycle, then req with addr 0x100.
   - First valid output is pc=0x100, pc_plus4=0x104.
5. Wrap: redirect to 0xFFFF_FFF8 with ack=1:
   - Outputs pc 0xFFFF_FFF8, then 0xFFFF_FFFC with pc_plus4=0x0, then pc 0x0.
6. rst asserted in HOLD with skid full and stall high:
   - Next cycle: if_valid_o=0, req=0, pc=RESET_PC, skid empty.
   - Fetch restarts at RESET_PC as in scenario 1.
